morse_symbol_decoder: RTL
=========================

# morse_symbol_decoder

Consumes the one-cycle symbol pulses from the Morse receive shift register and assembles them into ASCII bytes. The pulses are dot, dash, character_break, space and etx. Decoded bytes are buffered in a small FIFO and presented on a valid/ready byte stream to the receive-side consumer (UART bridge / display). It is the stage directly downstream of the receive shift register in the transceiver.

## Interface
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2
- UNKNOWN_CHAR, 8'h3F, byte emitted for an unmatched or overlong code
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- dot  input  1  one-cycle pulse, dot received
- dash  input  1  one-cycle pulse, dash received
- character_break  input  1  one-cycle pulse, end of character
- space  input  1  one-cycle pulse, end of word
- etx  input  1  one-cycle pulse, end of transmission
- out_data  output  8  FIFO head byte
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts out_data this cycle
- overflow  output  1  one-cycle pulse, event output dropped
- busy  output  1  accumulator holds ≥1 symbol, or FIFO non-empty

## Operation
- Accumulator: code[5:0] plus len[2:0] (0..6), plus an overlong flag.
- Symbol storage:
  - dot writes 0 and dash writes 1 into code[len], then len increments; the first symbol lands in bit 0.
  - Example: A (.-) is code=6'b000010, len=2.
  - A symbol arriving at len=6 sets overlong; code and len are unchanged.
- Flush: a pending character exists when len≠0 or overlong is set.
  - Lookup covers A–Z and 0–9 with standard ITU codes and uppercase ASCII.
  - Overlong or unmatched codes decode to UNKNOWN_CHAR.
  - After a flush, code, len and overlong clear.
- character_break: flush; push 1 byte if a character is pending, otherwise nothing.
- space: flush; push the pending byte (if any), then 8'h20.
- etx: flush; push the pending byte (if any), then 8'h03.
- Priority when several pulses arrive in one cycle: etx > space > character_break > dash > dot. Only the winner acts; the others are ignored.
- Push is atomic, with free space taken from the FIFO count at the start of the cycle. A pop in the same cycle does not free space.
- If free space is less than the bytes needed:
  - nothing is written;
  - overflow pulses for 1 cycle;
  - the accumulator still clears.
- Pop: out_valid && out_ready advances the head. Push and pop in the same cycle are both honoured, and the count changes by pushed−popped.
- Two-byte pushes write the character at the tail and the terminator at tail+1. Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values:
  - out_valid=0, out_data=8'h00, overflow=0, busy=0;
  - code, len and overlong=0;
  - FIFO pointers and count=0, storage cleared.
- Reset asserted mid-character or with a non-empty FIFO discards everything immediately (asynchronously).
- Latency: a terminating pulse in cycle N gives out_valid=1 and the byte on out_data in cycle N+1.
- The terminator byte of a two-byte push becomes the head once the character byte is popped, with no bubble.
- out_data is stable while out_valid=1 and out_ready=0.
- With out_ready held high, the stream sustains 1 byte per cycle.
- overflow is asserted in cycle N+1 for a dropped event in cycle N.
- Symbol pulses cause no output by themselves; the accumulator updates at the next edge.

## Test plan
- Single dot, then character_break → one byte 8'h45 ('E') one cycle later; busy returns to 0 after the pop.
- dot, dash, character_break; then dash, dash, dash, character_break → 8'h41 8'h4F ("AO").
- dash, then space → 8'h54, then 8'h20; with out_ready=1, they arrive on consecutive cycles.
- Seven dots, then etx → 8'h3F, then 8'h03; an empty-accumulator character_break emits nothing.
- Overflow:
  - Set out_ready=0; send "E" via character_break four times, which fills the FIFO.
  - A further "E"+character_break pulses overflow once; the FIFO still holds four 8'h45 bytes.
  - A character_break with an empty accumulator into the full FIFO needs 0 bytes, so overflow stays 0.
- Reset mid-operation:
  - Set out_ready=0; push 2 bytes and enter two dots.
  - Assert rst_n low for 1 cycle: out_valid drops to 0 immediately.
  - A subsequent dash + character_break → only 8'h54.

Source files
------------

// File: rtl/morse_symbol_decoder.sv
// morse_symbol_decoder: assembles Morse symbol pulses into ASCII bytes behind a small FIFO
//   clk, rst_n                         clock, asynchronous active-low reset
//   dot, dash                          one-cycle symbol pulses
//   character_break, space, etx        one-cycle terminator pulses
//   out_data, out_valid, out_ready     decoded byte stream (FIFO head)
//   overflow                           one-cycle pulse, terminator event dropped for lack of space
//   busy                               accumulator holds a symbol or FIFO non-empty
module morse_symbol_decoder #(
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] UNKNOWN_CHAR = 8'h3F
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dot,
    input  logic       dash,
    input  logic       character_break,
    input  logic       space,
    input  logic       etx,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overflow,
    output logic       busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [5:0]    code;
    logic [2:0]    len;
    logic          overlong;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          brk, sym, term, pending, fits, pop;
    logic [1:0]    need, push_n;
    logic [7:0]    ch, term_byte, byte0;

    // Code is stored first-symbol-in-bit-0 with dash=1; bits above len are always zero.
    function automatic logic [7:0] lookup(input logic [2:0] l, input logic [5:0] c);
        case ({l, c})
            {3'd2, 6'd2}:  lookup = 8'h41;
            {3'd4, 6'd1}:  lookup = 8'h42;
            {3'd4, 6'd5}:  lookup = 8'h43;
            {3'd3, 6'd1}:  lookup = 8'h44;
            {3'd1, 6'd0}:  lookup = 8'h45;
            {3'd4, 6'd4}:  lookup = 8'h46;
            {3'd3, 6'd3}:  lookup = 8'h47;
            {3'd4, 6'd0}:  lookup = 8'h48;
            {3'd2, 6'd0}:  lookup = 8'h49;
            {3'd4, 6'd14}: lookup = 8'h4A;
            {3'd3, 6'd5}:  lookup = 8'h4B;
            {3'd4, 6'd2}:  lookup = 8'h4C;
            {3'd2, 6'd3}:  lookup = 8'h4D;
            {3'd2, 6'd1}:  lookup = 8'h4E;
            {3'd3, 6'd7}:  lookup = 8'h4F;
            {3'd4, 6'd6}:  lookup = 8'h50;
            {3'd4, 6'd11}: lookup = 8'h51;
            {3'd3, 6'd2}:  lookup = 8'h52;
            {3'd3, 6'd0}:  lookup = 8'h53;
            {3'd1, 6'd1}:  lookup = 8'h54;
            {3'd3, 6'd4}:  lookup = 8'h55;
            {3'd4, 6'd8}:  lookup = 8'h56;
            {3'd3, 6'd6}:  lookup = 8'h57;
            {3'd4, 6'd9}:  lookup = 8'h58;
            {3'd4, 6'd13}: lookup = 8'h59;
            {3'd4, 6'd3}:  lookup = 8'h5A;
            {3'd5, 6'd31}: lookup = 8'h30;
            {3'd5, 6'd30}: lookup = 8'h31;
            {3'd5, 6'd28}: lookup = 8'h32;
            {3'd5, 6'd24}: lookup = 8'h33;
            {3'd5, 6'd16}: lookup = 8'h34;
            {3'd5, 6'd0}:  lookup = 8'h35;
            {3'd5, 6'd1}:  lookup = 8'h36;
            {3'd5, 6'd3}:  lookup = 8'h37;
            {3'd5, 6'd7}:  lookup = 8'h38;
            {3'd5, 6'd15}: lookup = 8'h39;
            default:       lookup = UNKNOWN_CHAR;
        endcase
    endfunction

    always_comb begin
        brk       = etx | space | character_break;
        term      = etx | space;
        sym       = (dot | dash) & ~brk;
        pending   = (len != 3'd0) | overlong;
        ch        = overlong ? UNKNOWN_CHAR : lookup(len, code);
        term_byte = etx ? 8'h03 : 8'h20;
        byte0     = pending ? ch : term_byte;
        need      = term ? 2'(pending) + 2'd1 : character_break ? 2'(pending) : 2'd0;
        // Free space is judged on the start-of-cycle count; a concurrent pop does not help.
        fits      = CW'(need) <= CW'(FIFO_DEPTH) - count;
        push_n    = fits ? need : 2'd0;
        pop       = out_valid & out_ready;
        out_valid = count != '0;
        out_data  = mem[head];
        busy      = pending | out_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code     <= '0;
            len      <= '0;
            overlong <= 1'b0;
        end else if (brk) begin
            code     <= '0;
            len      <= '0;
            overlong <= 1'b0;
        end else if (sym && len == 3'd6) begin
            overlong <= 1'b1;
        end else if (sym) begin
            code <= code | (6'(dash) << len);
            len  <= len + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_n != 2'd0) mem[tail] <= byte0;
            if (push_n == 2'd2) mem[tail + PW'(1)] <= term_byte;
            tail     <= tail + PW'(push_n);
            head     <= head + PW'(pop);
            count    <= count + CW'(push_n) - CW'(pop);
            overflow <= (need != 2'd0) & ~fits;
        end
    end
endmodule
